reg_access_ctrl: RTL and testbench

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_access_pkg.sv | 26 ++
 rtl/reg_access_fifo.sv | 66 ++++++
 rtl/reg_access_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_access_pkg.sv
// Shared definitions for the register access controller: default widths,
// the access timeout length and the controller state encoding.
package reg_access_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_REGS   = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  // Number of ACCESS cycles without dec_ready before the access is abandoned.
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A buffered request is {write, addr, wdata}.
  function automatic int entry_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/reg_access_fifo.sv
// Small synchronous request buffer with show-ahead read data.
// A push while full or a pop while empty is ignored.
module reg_access_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so non power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register access controller: buffers requests, runs each through a
// SETUP/ACCESS handshake on the decoder side and returns an in-order response.
// Out-of-range addresses bypass the decoder and answer with an error.
// Optional build macro REG_ACCESS_WAIT_EN adds the dec_ready input: ACCESS
// then waits for dec_ready and gives up with an error after TIMEOUT_CYCLES.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              dec_sel,
  output logic              dec_en,
  output logic              dec_wr,
  output logic [ADDR_W-1:0] dec_addr,
  output logic [DATA_W-1:0] dec_wdata,
`ifdef REG_ACCESS_WAIT_EN
  input  logic              dec_ready,
`endif
  input  logic [DATA_W-1:0] dec_rdata
);

  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);

  state_t              state;
  state_t              state_nxt;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_din;
  logic [ENTRY_W-1:0]  fifo_dout;

  logic                head_write;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;
  logic                head_ok;

  logic                load_ok;
  logic                load_err;
  logic                acc_done;
  logic                acc_err;
  logic                wr_q;

  // Address check done in 64 bits so NUM_REGS = 2**ADDR_W is handled.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return 64'(a) < 64'(NUM_REGS);
  endfunction

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_din  = {req_write, req_addr, req_wdata};

  assign head_write = fifo_dout[ENTRY_W-1];
  assign head_addr  = fifo_dout[DATA_W +: ADDR_W];
  assign head_wdata = fifo_dout[DATA_W-1:0];
  assign head_ok    = addr_in_range(head_addr);

  reg_access_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef REG_ACCESS_WAIT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // Counts consecutive ACCESS cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_ACCESS) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, FIFO pop and the load/complete strobes for the datapath.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_ok   = 1'b0;
    load_err  = 1'b0;
    acc_done  = 1'b0;
    acc_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_ok) begin
            load_ok   = 1'b1;
            state_nxt = ST_SETUP;
          end else begin
            load_err  = 1'b1;
            state_nxt = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
`ifdef REG_ACCESS_WAIT_EN
        if (dec_ready) begin
          acc_done = 1'b1;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          acc_done = 1'b1;
          acc_err  = 1'b1;
        end
`else
        acc_done = 1'b1;
`endif
        if (acc_done) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Decoder request fields latched on pop; response captured when ACCESS ends.
  // These drive outputs directly, so they are reset to give all-zero outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      dec_addr  <= '0;
      dec_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (load_ok) begin
        wr_q      <= head_write;
        dec_addr  <= head_addr;
        dec_wdata <= head_wdata;
      end
      if (load_ok || load_err) begin
        rsp_rdata <= '0;
        rsp_err   <= load_err;
      end
      if (acc_done) begin
        rsp_rdata <= (wr_q || acc_err) ? '0 : dec_rdata;
        rsp_err   <= acc_err;
      end
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign dec_sel   = (state == ST_SETUP) || (state == ST_ACCESS);
  assign dec_en    = (state == ST_ACCESS);
  assign dec_wr    = wr_q && dec_sel;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a small 8-entry register decoder model.
module tb_reg_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_ready = 1'b1;
  logic       dec_ready = 1'b1;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       dec_sel;
  logic       dec_en;
  logic       dec_wr;
  logic [7:0] dec_addr;
  logic [7:0] dec_wdata;
  logic [7:0] dec_rdata;

  int total = 0;
  int bad = 0;
  int sel_cnt = 0;
  logic [7:0] regs [8];

  always #5 clk = ~clk;

  reg_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dec_sel   (dec_sel),
    .dec_en    (dec_en),
    .dec_wr    (dec_wr),
    .dec_addr  (dec_addr),
    .dec_wdata (dec_wdata),
`ifdef REG_ACCESS_WAIT_EN
    .dec_ready (dec_ready),
`endif
    .dec_rdata (dec_rdata)
  );

  // Downstream register decoder model, cleared by the same reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (dec_en && dec_wr && dec_ready && dec_addr < 8) begin
      regs[dec_addr[2:0]] <= dec_wdata;
    end
  end
  assign dec_rdata = (dec_sel && dec_addr < 8) ? regs[dec_addr[2:0]] : 8'h00;

  // Counts cycles with dec_sel high so bypass paths can be checked.
  always @(posedge clk) begin
    if (dec_sel) sel_cnt <= sel_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int g = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    while (!req_ready && g < 60) begin @(negedge clk); g++; end
    if (g >= 60) check("req_wait", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for a response, samples it and completes the handshake.
  task automatic get_rsp(output logic [7:0] rd, output logic er);
    int g = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && g < 60) begin @(negedge clk); g++; end
    check("rsp_wait", rsp_valid, 1);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic er);
    send(wr, a, d);
    get_rsp(rd, er);
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    logic [7:0] vals [8];
    int         n;
    int         g;
    int         sel0;

    // Outputs while reset is applied.
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_outs", {rsp_valid, rsp_err, rsp_rdata, dec_sel, dec_en, dec_wr, dec_addr, dec_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Cycle-by-cycle latency of a write to addr 3.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd3; req_wdata = 8'hA5;
    check("lat_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("lat_k1", {rsp_valid, dec_sel, dec_en}, 3'b000);
    @(negedge clk);
    check("setup_ctl", {dec_sel, dec_en, dec_wr}, 3'b101);
    check("setup_addr", dec_addr, 8'd3);
    check("setup_wdata", dec_wdata, 8'hA5);
    @(negedge clk);
    check("access_ctl", {rsp_valid, dec_sel, dec_en, dec_wr}, 4'b0111);
    check("access_addr", dec_addr, 8'd3);
    @(negedge clk);
    check("resp_ctl", {rsp_valid, rsp_err, dec_sel, dec_en, dec_wr}, 5'b10000);
    check("resp_wr_rdata", rsp_rdata, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("resp_done", rsp_valid, 0);

    // Read back addr 3.
    txn(1'b0, 8'd3, 8'h00, rd, er);
    check("rd3_data", rd, 8'hA5);
    check("rd3_err", er, 0);

    // Out-of-range read: one cycle after IDLE, no decoder select.
    sel0 = sel_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd8; req_wdata = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("err_k1", {rsp_valid, dec_sel}, 2'b00);
    @(negedge clk);
    check("err_vld", rsp_valid, 1);
    check("err_flag", rsp_err, 1);
    check("err_rdata", rsp_rdata, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("err_nosel", sel_cnt - sel0, 0);

    // Fill a few registers, then three back-to-back reads with rsp_ready low.
    txn(1'b1, 8'd1, 8'h11, rd, er);
    txn(1'b1, 8'd2, 8'h22, rd, er);
    txn(1'b1, 8'd6, 8'h66, rd, er);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd1;
    check("bb_rdy_a", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 8'd2;
    check("bb_rdy_b", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 8'd6;
    check("bb_rdy_c", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bb_full", req_ready, 0);
    repeat (4) @(negedge clk);
    check("bb_hold", {rsp_valid, req_ready}, 2'b10);
    check("bb_hold_data", rsp_rdata, 8'h11);
    get_rsp(rd, er);
    check("bb_rsp1", {er, rd}, {1'b0, 8'h11});
    get_rsp(rd, er);
    check("bb_rsp2", {er, rd}, {1'b0, 8'h22});
    get_rsp(rd, er);
    check("bb_rsp3", {er, rd}, {1'b0, 8'h66});

    // Leave non-zero state behind, then check every output clears in reset.
    txn(1'b1, 8'd7, 8'h77, rd, er);
    txn(1'b0, 8'hFF, 8'h00, rd, er);
    check("err_ff", {er, rd}, {1'b1, 8'h00});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst2_ready", req_ready, 1);
    check("rst2_outs", {rsp_valid, rsp_err, rsp_rdata, dec_sel, dec_en, dec_wr, dec_addr, dec_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write all registers, confirm one, reset, then all read back as zero.
    for (int i = 0; i < 8; i++) begin
      vals[i] = 8'($urandom_range(1, 255));
      txn(1'b1, 8'(i), vals[i], rd, er);
    end
    txn(1'b0, 8'd7, 8'h00, rd, er);
    check("rnd_rd7", rd, vals[7]);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst3_rdata", rsp_rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, 8'(i), 8'h00, rd, er);
      check($sformatf("post_rst_rd%0d", i), {er, rd}, 9'h000);
    end

    // Reset during the ACCESS of a write to addr 5, with a read queued behind it.
    send(1'b1, 8'd5, 8'h5A);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_access", dec_en, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_deassert", {dec_sel, dec_en}, 2'b00);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) n++;
      @(negedge clk);
    end
    check("mid_norsp", n, 0);
    check("mid_empty", req_ready, 1);
    txn(1'b0, 8'd5, 8'h00, rd, er);
    check("mid_rd5", {er, rd}, 9'h000);
    repeat (6) @(negedge clk);
    check("mid_noextra", rsp_valid, 0);

`ifdef REG_ACCESS_WAIT_EN
    // Timeout after 16 ACCESS cycles with dec_ready held low.
    txn(1'b1, 8'd4, 8'h44, rd, er);
    dec_ready = 1'b0;
    send(1'b0, 8'd4, 8'h00);
    n = 0; g = 0;
    while (!rsp_valid && g < 60) begin
      if (dec_en) n++;
      @(negedge clk);
      g++;
    end
    check("tmo_cycles", n, 16);
    get_rsp(rd, er);
    check("tmo_rsp", {er, rd}, {1'b1, 8'h00});

    // dec_ready on the third ACCESS cycle completes normally.
    send(1'b0, 8'd4, 8'h00);
    n = 0; g = 0;
    while (!rsp_valid && g < 60) begin
      if (dec_en) begin
        n++;
        if (n == 3) dec_ready = 1'b1;
      end
      @(negedge clk);
      g++;
    end
    check("wait_cycles", n, 3);
    get_rsp(rd, er);
    check("wait_rsp", {er, rd}, {1'b0, 8'h44});
    dec_ready = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
